// File: rtl/rng_sw_reset_ctrl.sv
// Software-reset sequencer for the TRNG: waits for the datapath to go idle (bounded),
// pulses rng_sw_reset, then holds off new requests while the downstream reset pipeline settles.
module rng_sw_reset_ctrl #(
    parameter int PULSE_CYCLES = 4,
    parameter int GUARD_CYCLES = 8,
    parameter int QUIESCE_MAX  = 12,
    parameter int CNT_W        = 4
) (
    input  logic clk,
    input  logic sys_rst,
    input  logic sw_reset_req,
    input  logic trng_busy,
    input  logic err_clr,
    output logic rng_sw_reset,
    output logic sw_reset_ack,
    output logic sw_reset_busy,
    output logic sw_reset_done,
    output logic quiesce_timeout,
    output logic req_overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUIESCE = 2'd1,
        PULSE   = 2'd2,
        GUARD   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] QUIESCE_LOAD = CNT_W'(QUIESCE_MAX - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD   = CNT_W'(GUARD_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             ack_next;
    logic             done_next;
    logic             timeout_set;
    logic             overrun_set;

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        ack_next    = 1'b0;
        done_next   = 1'b0;
        timeout_set = 1'b0;
        overrun_set = 1'b0;

        case (state)
            IDLE: begin
                if (sw_reset_req) begin
                    state_next = QUIESCE;
                    cnt_next   = QUIESCE_LOAD;
                    ack_next   = 1'b1;
                end
            end
            QUIESCE: begin
                if (!trng_busy) begin
                    state_next = PULSE;
                    cnt_next   = PULSE_LOAD;
                end else if (cnt == '0) begin
                    // Datapath never went idle: force the reset anyway and flag it.
                    state_next  = PULSE;
                    cnt_next    = PULSE_LOAD;
                    timeout_set = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_next = GUARD;
                    cnt_next   = GUARD_LOAD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            GUARD: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        if (state != IDLE && sw_reset_req) begin
            overrun_set = 1'b1;
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state           <= IDLE;
            cnt             <= '0;
            rng_sw_reset    <= 1'b0;
            sw_reset_ack    <= 1'b0;
            sw_reset_busy   <= 1'b0;
            sw_reset_done   <= 1'b0;
            quiesce_timeout <= 1'b0;
            req_overrun     <= 1'b0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            rng_sw_reset    <= (state_next == PULSE);
            sw_reset_ack    <= ack_next;
            sw_reset_busy   <= (state_next != IDLE);
            sw_reset_done   <= done_next;
            quiesce_timeout <= timeout_set | (quiesce_timeout & ~err_clr);
            req_overrun     <= overrun_set | (req_overrun & ~err_clr);
        end
    end

endmodule

// File: tb/tb_rng_sw_reset_ctrl.sv
// Self-checking bench for rng_sw_reset_ctrl: default instance plus a PULSE=1/GUARD=5 instance,
// table-driven request vectors with a scoreboard queue and hand-written corner-case sequences.
module tb_rng_sw_reset_ctrl;

    logic clk = 1'b0;
    logic sys_rst;
    logic req;
    logic trng_busy;
    logic err_clr;
    bit   sel;

    logic req_a, req_b;
    logic pulse_a, ack_a, busy_a, done_a, tout_a, ovr_a;
    logic pulse_b, ack_b, busy_b, done_b, tout_b, ovr_b;
    logic pulse, ack, busy, done, tout, ovr;

    assign req_a = req & ~sel;
    assign req_b = req & sel;
    assign pulse = sel ? pulse_b : pulse_a;
    assign ack   = sel ? ack_b   : ack_a;
    assign busy  = sel ? busy_b  : busy_a;
    assign done  = sel ? done_b  : done_a;
    assign tout  = sel ? tout_b  : tout_a;
    assign ovr   = sel ? ovr_b   : ovr_a;

    always #5 clk = ~clk;

    rng_sw_reset_ctrl dut_a (
        .clk             (clk),
        .sys_rst         (sys_rst),
        .sw_reset_req    (req_a),
        .trng_busy       (trng_busy),
        .err_clr         (err_clr),
        .rng_sw_reset    (pulse_a),
        .sw_reset_ack    (ack_a),
        .sw_reset_busy   (busy_a),
        .sw_reset_done   (done_a),
        .quiesce_timeout (tout_a),
        .req_overrun     (ovr_a)
    );

    rng_sw_reset_ctrl #(
        .PULSE_CYCLES (1),
        .GUARD_CYCLES (5),
        .QUIESCE_MAX  (12),
        .CNT_W        (4)
    ) dut_b (
        .clk             (clk),
        .sys_rst         (sys_rst),
        .sw_reset_req    (req_b),
        .trng_busy       (trng_busy),
        .err_clr         (err_clr),
        .rng_sw_reset    (pulse_b),
        .sw_reset_ack    (ack_b),
        .sw_reset_busy   (busy_b),
        .sw_reset_done   (done_b),
        .quiesce_timeout (tout_b),
        .req_overrun     (ovr_b)
    );

    typedef struct {
        bit sel;
        int busy_cycles;
        int exp_ps;
        int exp_len;
        int exp_done;
        bit exp_to;
    } vec_t;

    typedef struct {
        int ps;
        int len;
        int done;
        bit to;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;

    task automatic check_bit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
        end
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic clear_flags();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    // One request; offsets count cycles after the sampling edge, so the ack lands at offset 1.
    task automatic apply_stimulus(input vec_t v);
        int   ps, len, done_off, ack_cnt, ack_off, busy_err;
        logic to_at_done, ovr_at_done;
        exp_t e;
        ps = -1; len = 0; done_off = -1; ack_cnt = 0; ack_off = -1; busy_err = 0;
        to_at_done = 1'b0; ovr_at_done = 1'b0;
        sel = v.sel;
        @(negedge clk);
        req = 1'b1;
        e.ps = v.exp_ps; e.len = v.exp_len; e.done = v.exp_done; e.to = v.exp_to;
        sb_q.push_back(e);
        for (int off = 1; off <= 40; off++) begin
            @(negedge clk);
            req = 1'b0;
            if (pulse === 1'b1) begin
                if (ps < 0) ps = off;
                len++;
            end
            if (ack === 1'b1) begin
                ack_cnt++;
                ack_off = off;
            end
            if (busy !== (off < v.exp_done)) busy_err++;
            if (done === 1'b1) begin
                done_off    = off;
                to_at_done  = tout;
                ovr_at_done = ovr;
                break;
            end
            trng_busy = (off <= v.busy_cycles);
        end
        trng_busy = 1'b0;
        e = sb_q.pop_front();
        check_output("pulse_start", ps, e.ps);
        check_output("pulse_len", len, e.len);
        check_output("done_offset", done_off, e.done);
        check_output("ack_count", ack_cnt, 1);
        check_output("ack_offset", ack_off, 1);
        check_output("busy_errors", busy_err, 0);
        check_bit("timeout_flag", to_at_done, e.to);
        check_bit("overrun_flag", ovr_at_done, 1'b0);
        if (e.to) begin
            clear_flags();
            check_bit("timeout_cleared", tout, 1'b0);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 0,  2, 4, 14, 1'b0};
        vecs[1] = '{1'b0, 5,  7, 4, 19, 1'b0};
        vecs[2] = '{1'b0, 99, 13, 4, 25, 1'b1};
        vecs[3] = '{1'b0, 11, 13, 4, 25, 1'b0};
        vecs[4] = '{1'b1, 0,  2, 1, 8,  1'b0};
        vecs[5] = '{1'b1, 3,  5, 1, 11, 1'b0};
        vecs[6] = '{1'b1, 99, 13, 1, 19, 1'b1};

        sys_rst = 1'b1; req = 1'b0; trng_busy = 1'b0; err_clr = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("rst_pulse_a", pulse_a, 1'b0);
        check_bit("rst_ack_a", ack_a, 1'b0);
        check_bit("rst_busy_a", busy_a, 1'b0);
        check_bit("rst_done_a", done_a, 1'b0);
        check_bit("rst_tout_a", tout_a, 1'b0);
        check_bit("rst_ovr_a", ovr_a, 1'b0);
        check_bit("rst_pulse_b", pulse_b, 1'b0);
        check_bit("rst_busy_b", busy_b, 1'b0);
        check_bit("rst_done_b", done_b, 1'b0);
        check_bit("rst_tout_b", tout_b, 1'b0);
        sys_rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i]);
            repeat (2) @(negedge clk);
        end

        // Overrun: extra requests during PULSE and the last GUARD cycle, then one in the first IDLE cycle.
        begin
            int ack_early, done_cnt, ack_total;
            ack_early = 0; done_cnt = 0; ack_total = 0;
            sel = 1'b0;
            @(negedge clk);
            req = 1'b1;
            for (int off = 1; off <= 30; off++) begin
                @(negedge clk);
                req = 1'b0;
                if (ack === 1'b1) begin
                    ack_total++;
                    if (off >= 2 && off <= 14) ack_early++;
                end
                if (done === 1'b1) done_cnt++;
                if (off == 4) check_bit("ovr_set_in_pulse", ovr, 1'b1);
                if (off == 14) check_bit("ovr_done_first", done, 1'b1);
                if (off == 15) check_bit("ovr_reack", ack, 1'b1);
                req = (off == 3 || off == 13 || off == 14);
            end
            check_output("ovr_dropped_acks", ack_early, 0);
            check_output("ovr_total_acks", ack_total, 2);
            check_output("ovr_done_count", done_cnt, 2);
            clear_flags();
            check_bit("ovr_cleared", ovr, 1'b0);
        end
        repeat (2) @(negedge clk);

        // Reset in the second PULSE cycle with the overrun flag already set.
        begin
            int done_cnt;
            done_cnt = 0;
            sel = 1'b0;
            @(negedge clk);
            req = 1'b1;
            for (int off = 1; off <= 25; off++) begin
                @(negedge clk);
                req = 1'b0;
                sys_rst = 1'b0;
                if (done === 1'b1) done_cnt++;
                if (off == 3) begin
                    check_bit("rstmid_pulse_before", pulse, 1'b1);
                    check_bit("rstmid_ovr_before", ovr, 1'b1);
                end
                if (off == 4) begin
                    check_bit("rstmid_pulse", pulse, 1'b0);
                    check_bit("rstmid_busy", busy, 1'b0);
                    check_bit("rstmid_ovr", ovr, 1'b0);
                    check_bit("rstmid_tout", tout, 1'b0);
                end
                sys_rst = (off == 3);
                req = (off == 2);
            end
            check_output("rstmid_done_count", done_cnt, 0);
            apply_stimulus(vecs[0]);
        end
        repeat (2) @(negedge clk);

        // Set/clear collisions on the short-parameter instance with a stuck-busy TRNG.
        begin
            sel = 1'b1;
            @(negedge clk);
            req = 1'b1;
            for (int off = 1; off <= 20; off++) begin
                @(negedge clk);
                req = 1'b0;
                err_clr = 1'b0;
                if (off == 13) begin
                    check_bit("coll_tout_kept", tout, 1'b1);
                    check_bit("coll_pulse_on", pulse, 1'b1);
                end
                if (off == 14) check_bit("coll_pulse_off", pulse, 1'b0);
                if (off == 15) begin
                    check_bit("coll_ovr_kept", ovr, 1'b1);
                    check_bit("coll_tout_cleared", tout, 1'b0);
                end
                if (off == 19) check_bit("coll_done", done, 1'b1);
                trng_busy = (off <= 12);
                err_clr = (off == 12 || off == 14);
                req = (off == 14);
            end
            trng_busy = 1'b0;
            clear_flags();
            check_bit("coll_ovr_cleared", ovr, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rng_sw_reset_ctrl.md
# rng_sw_reset_ctrl

Software-reset sequencer for the TRNG: the issuing end of the `rng_sw_reset` request that the TRNG reset generator consumes. It accepts a one-cycle software reset request from the register block and first waits for the TRNG datapath to go idle, bounded by a timeout. It then drives `rng_sw_reset` high for a programmed number of cycles and holds off further requests for a guard window that covers the downstream 4-flop reset pipeline. Completion, busy and error status are reported back to the register block.

## Interface
- `PULSE_CYCLES`, 4: cycles `rng_sw_reset` is held high; legal range 1..2^CNT_W-1.
- `GUARD_CYCLES`, 8: cycles after the pulse before a new request is accepted; legal range 5..2^CNT_W-1, must exceed the 4-stage downstream pipeline.
- `QUIESCE_MAX`, 12: maximum cycles spent waiting for `trng_busy` to fall; legal range 1..2^CNT_W-1.
- `CNT_W`, 4: width of the single shared down-counter.
- `clk`  input  1  sole clock; all logic on posedge.
- `sys_rst`  input  1  reset; synchronous and active-high.
- `sw_reset_req`  input  1  one-cycle request strobe (register write, bit set).
- `trng_busy`  input  1  TRNG sampling or collection in progress.
- `err_clr`  input  1  clears the sticky error flags.
- `rng_sw_reset`  output  1  reset request to the TRNG reset generator (active-high, registered).
- `sw_reset_ack`  output  1  one-cycle pulse: request accepted.
- `sw_reset_busy`  output  1  high in every state except IDLE.
- `sw_reset_done`  output  1  one-cycle pulse when the sequence completes.
- `quiesce_timeout`  output  1  sticky: a reset was forced while `trng_busy` was still high.
- `req_overrun`  output  1  sticky: a request arrived while not in IDLE.

## Operation
- FSM states: IDLE, QUIESCE, PULSE, GUARD. One counter `cnt[CNT_W-1:0]`.
- **IDLE**
  - `sw_reset_req`=1 → QUIESCE, load `cnt`=QUIESCE_MAX-1, assert `sw_reset_ack` for one cycle.
- **QUIESCE**
  - `trng_busy`=0 → PULSE, load `cnt`=PULSE_CYCLES-1.
  - `trng_busy`=1 with `cnt`==0 → PULSE, set `quiesce_timeout`.
  - Otherwise decrement `cnt`.
- **PULSE**
  - `rng_sw_reset`=1.
  - `cnt`==0 → GUARD, load `cnt`=GUARD_CYCLES-1; otherwise decrement.
- **GUARD**
  - `cnt`==0 → IDLE, assert `sw_reset_done` in the same registered update; otherwise decrement.
- **Overrun**
  - `sw_reset_req` while not in IDLE is dropped and sets `req_overrun`.
  - This includes the final GUARD cycle. The first cycle back in IDLE accepts a request normally.
- **Sticky flags**
  - Cleared by `err_clr`.
  - If set and clear conditions occur in the same cycle, set wins.
- **Ignored input**
  - `trng_busy` is ignored outside QUIESCE.
- **Outputs**
  - All outputs are flops: no combinational path from inputs to outputs.
- **Reset** (`sys_rst`=1 at a clock edge)
  - State becomes IDLE, `cnt`=0, and every output is 0, including the sticky flags.
  - Reset mid-sequence drops `rng_sw_reset` at that edge. No `sw_reset_done` is emitted.

## Timing
- Request sampled at edge E0: `sw_reset_ack`=1 and `sw_reset_busy`=1 during cycle E0+1.
- With `trng_busy`=0 at E1: `rng_sw_reset` is high for exactly PULSE_CYCLES cycles, E2 through E2+PULSE_CYCLES-1.
- Guard window: GUARD_CYCLES cycles immediately after the pulse.
- `sw_reset_done`: high for one cycle, the first IDLE cycle, at E2+PULSE_CYCLES+GUARD_CYCLES. `sw_reset_busy` is 0 in that cycle.
- Minimum request-to-done latency: 2+PULSE_CYCLES+GUARD_CYCLES cycles (14 with defaults).
- Each QUIESCE cycle with `trng_busy`=1 adds one cycle.
- Maximum QUIESCE duration: QUIESCE_MAX cycles.
- Maximum request-to-done latency: 1+QUIESCE_MAX+PULSE_CYCLES+GUARD_CYCLES cycles (25 with defaults).

## Test plan
- **Defaults, idle TRNG.** Stimulus: `trng_busy`=0, `sw_reset_req` pulse at E0. Required: ack at E1; `rng_sw_reset` high E2..E5 (4 cycles); done at E14; busy high E1..E13; no flags set.
- **Busy TRNG releases.** Stimulus: `trng_busy` high for 5 cycles after the request. Required: pulse starts 5 cycles later than the idle case; done at E19; `quiesce_timeout`=0.
- **Stuck-busy TRNG.** Stimulus: `trng_busy` held high. Required: pulse forced after 12 QUIESCE cycles, starting at E13; `quiesce_timeout`=1; done at E25. `err_clr` then clears the flag.
- **Overrun.** Stimulus: second request during PULSE, then another in the final GUARD cycle. Required: no extra ack; `req_overrun`=1; exactly one done. A request in the first IDLE cycle after done is acked.
- **Reset mid-pulse.** Stimulus: `sys_rst` asserted in the 2nd PULSE cycle. Required: at that edge `rng_sw_reset`=0, busy=0, flags=0; no done pulse. A new request afterwards follows the exact timing of the first scenario.
- **Set/clear collision and non-default parameters.** Stimulus: `err_clr` in the same cycle as a timeout or overrun; PULSE_CYCLES=1, GUARD_CYCLES=5. Required: the flag remains set; pulse is exactly 1 cycle; done at E8.
